nanci_sort_pe: RTL and testbench

- One processing element of the Nanci linear sorting array; N instances are chained by index 0..N-1.
- Each PE holds one packet {valid, addr, data} and runs odd-even transposition compare-exchange with its left and right neighbours for SORT_CYCLES cycles.
- When sorting ends, PE k holds the packet whose addr is k. The PE then presents that packet as its result to the application layer downstream.

---
 rtl/nanci_sort_pe.sv | 104 ++++++++++
 tb/tb_nanci_sort_pe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/nanci_sort_pe.sv
// One processing element of the Nanci linear sorting array: holds a single
// {valid, addr, data} packet and runs odd-even transposition against its neighbours.
module nanci_sort_pe #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 4,
    parameter int N           = 16,
    parameter int INDEX       = 0,
    parameter int SORT_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load,
    input  logic [ADDR_WIDTH+DATA_WIDTH:0] load_elem,
    input  logic [ADDR_WIDTH+DATA_WIDTH:0] left_elem,
    input  logic [ADDR_WIDTH+DATA_WIDTH:0] right_elem,
    output logic [ADDR_WIDTH+DATA_WIDTH:0] elem_out,
    output logic                           busy,
    output logic                           done,
    output logic [ADDR_WIDTH+DATA_WIDTH:0] result
);

    localparam int W     = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int KW    = 1 + ADDR_WIDTH;
    localparam int CNT_W = (SORT_CYCLES > 1) ? $clog2(SORT_CYCLES + 1) : 1;

    localparam logic             HAS_LEFT  = (INDEX > 0);
    localparam logic             HAS_RIGHT = (INDEX < N - 1);
    localparam logic             IDX_ODD   = ((INDEX % 2) != 0);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SORT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SORT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_elem;
    logic [W-1:0]     r_result;
    logic             r_busy;
    logic             r_done;

    logic             w_look_right;
    logic [W-1:0]     w_next;

    // Inverting valid makes empty slots rank above every real packet.
    function automatic logic [KW-1:0] key_of(input logic [W-1:0] e);
        return {~e[W-1], e[W-2 -: ADDR_WIDTH]};
    endfunction

    assign w_look_right = ~(IDX_ODD ^ r_cnt[0]);

    always_comb begin
        w_next = r_elem;
        if (w_look_right) begin
            if (HAS_RIGHT && (key_of(right_elem) < key_of(r_elem)))
                w_next = right_elem;
        end else begin
            if (HAS_LEFT && (key_of(left_elem) > key_of(r_elem)))
                w_next = left_elem;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_elem   <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (load) begin
            r_state  <= S_SORT;
            r_cnt    <= '0;
            r_elem   <= load_elem;
            r_result <= '0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_SORT: begin
                    r_elem <= w_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_result <= w_next;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign elem_out = r_elem;
    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;

endmodule

// File: tb/tb_nanci_sort_pe.sv
// Directed bench: a 16-PE chain, a 4-PE chain and a lone PE with hand-driven neighbours.
module tb_nanci_sort_pe;

    localparam int W = 37;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic v, input logic [3:0] a, input logic [31:0] d);
        return {v, a, d};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Chain A: N=16
    logic         a_load = 1'b0;
    logic [W-1:0] a_ld   [16];
    logic [W-1:0] a_out  [16];
    logic [W-1:0] a_res  [16];
    logic         a_busy [16];
    logic         a_done [16];
    logic [W-1:0] a_ext  [18];

    assign a_ext[0]  = '0;
    assign a_ext[17] = '0;
    for (genvar k = 0; k < 16; k++) begin : g_a
        nanci_sort_pe #(.N(16), .INDEX(k), .SORT_CYCLES(16)) u_pe (
            .clk(clk), .rst(rst), .load(a_load), .load_elem(a_ld[k]),
            .left_elem(a_ext[k]), .right_elem(a_ext[k+2]),
            .elem_out(a_out[k]), .busy(a_busy[k]), .done(a_done[k]), .result(a_res[k])
        );
        assign a_ext[k+1] = a_out[k];
    end

    // Chain B: N=4
    logic         b_load = 1'b0;
    logic [W-1:0] b_ld   [4];
    logic [W-1:0] b_out  [4];
    logic [W-1:0] b_res  [4];
    logic         b_busy [4];
    logic         b_done [4];
    logic [W-1:0] b_ext  [6];

    assign b_ext[0] = '0;
    assign b_ext[5] = '0;
    for (genvar k = 0; k < 4; k++) begin : g_b
        nanci_sort_pe #(.N(4), .INDEX(k), .SORT_CYCLES(4)) u_pe (
            .clk(clk), .rst(rst), .load(b_load), .load_elem(b_ld[k]),
            .left_elem(b_ext[k]), .right_elem(b_ext[k+2]),
            .elem_out(b_out[k]), .busy(b_busy[k]), .done(b_done[k]), .result(b_res[k])
        );
        assign b_ext[k+1] = b_out[k];
    end

    // Lone PE: INDEX=2 of N=4, neighbours driven by the bench
    logic         c_load  = 1'b0;
    logic [W-1:0] c_ld    = '0;
    logic [W-1:0] c_left  = '0;
    logic [W-1:0] c_right = '0;
    logic [W-1:0] c_out;
    logic [W-1:0] c_res;
    logic         c_busy;
    logic         c_done;

    nanci_sort_pe #(.N(4), .INDEX(2), .SORT_CYCLES(4)) u_c (
        .clk(clk), .rst(rst), .load(c_load), .load_elem(c_ld),
        .left_elem(c_left), .right_elem(c_right),
        .elem_out(c_out), .busy(c_busy), .done(c_done), .result(c_res)
    );

    task automatic pulse_a();
        a_load = 1'b1;
        step(1);
        a_load = 1'b0;
    endtask

    task automatic pulse_b();
        b_load = 1'b1;
        step(1);
        b_load = 1'b0;
    endtask

    task automatic pulse_c();
        c_load = 1'b1;
        step(1);
        c_load = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 16; k++) a_ld[k] = '0;
        for (int k = 0; k < 4; k++)  b_ld[k] = '0;
        rst = 1'b1;
        step(2);
        rst = 1'b0;

        // Reset state
        chk("rst_out",  a_out[5],  '0);
        chk("rst_busy", a_busy[5], 0);
        chk("rst_done", b_done[1], 0);
        chk("rst_res",  c_res,     '0);

        // IDLE ignores neighbours
        c_right = mk(1, 3, 32'hB);
        c_left  = mk(1, 7, 32'hC);
        step(2);
        chk("idle_hold", c_out, '0);

        // Lone PE: right exchange in phase 0, left exchange in phase 1
        c_ld = mk(1, 5, 32'hA);
        pulse_c();
        chk("c_load",     c_out,  mk(1, 5, 32'hA));
        chk("c_busy",     c_busy, 1);
        chk("c_res_busy", c_res,  '0);
        step(1);
        chk("c_ph0", c_out, mk(1, 3, 32'hB));
        step(1);
        chk("c_ph1", c_out, mk(1, 7, 32'hC));
        c_right = mk(0, 0, 32'hD);
        c_left  = mk(1, 1, 32'hE);
        step(1);
        chk("c_ph2_invalid", c_out, mk(1, 7, 32'hC));
        step(1);
        chk("c_ph3_small", c_out,  mk(1, 7, 32'hC));
        chk("c_done",      c_done, 1);
        chk("c_busy_end",  c_busy, 0);
        chk("c_result",    c_res,  mk(1, 7, 32'hC));
        c_left = mk(0, 15, 32'hF);
        step(3);
        chk("c_done_hold", c_out, mk(1, 7, 32'hC));
        chk("c_res_hold",  c_res, mk(1, 7, 32'hC));

        // Invalid packets sink to the high end
        b_ld[0] = mk(0, 3, 32'd3);
        b_ld[1] = mk(1, 1, 32'd1);
        b_ld[2] = mk(0, 2, 32'd2);
        b_ld[3] = mk(1, 0, 32'd0);
        pulse_b();
        step(3);
        chk("inv_early", b_done[0], 0);
        step(1);
        chk("inv_done", b_done[3], 1);
        chk("inv_r0", b_res[0], mk(1, 0, 32'd0));
        chk("inv_r1", b_res[1], mk(1, 1, 32'd1));
        chk("inv_r2", b_res[2], mk(0, 2, 32'd2));
        chk("inv_r3", b_res[3], mk(0, 3, 32'd3));

        // Equal keys keep their order
        b_ld[0] = mk(1, 3, 32'h30);
        b_ld[1] = mk(1, 2, 32'h1);
        b_ld[2] = mk(1, 2, 32'h2);
        b_ld[3] = mk(1, 0, 32'h40);
        pulse_b();
        chk("eq_res_cleared", b_res[0], '0);
        step(4);
        chk("eq_r0", b_res[0], mk(1, 0, 32'h40));
        chk("eq_r1", b_res[1], mk(1, 2, 32'h1));
        chk("eq_r2", b_res[2], mk(1, 2, 32'h2));
        chk("eq_r3", b_res[3], mk(1, 3, 32'h30));
        step(3);
        chk("eq_persist", b_res[2], mk(1, 2, 32'h2));

        // Reverse-order 16-PE chain
        for (int k = 0; k < 16; k++) a_ld[k] = mk(1, 4'(15 - k), 32'(k));
        pulse_a();
        step(15);
        chk("rev_early", a_done[0], 0);
        step(1);
        chk("rev_done0",  a_done[0],  1);
        chk("rev_done15", a_done[15], 1);
        for (int j = 0; j < 16; j++)
            chk($sformatf("rev_r%0d", j), a_res[j], mk(1, 4'(j), 32'(15 - j)));

        // Restart mid-sort: addr = 7k mod 16, so PE j ends with data from PE 7j mod 16
        for (int k = 0; k < 16; k++) a_ld[k] = mk(1, 4'((3 * k) % 16), 32'hDEAD);
        pulse_a();
        step(6);
        for (int k = 0; k < 16; k++) a_ld[k] = mk(1, 4'((7 * k) % 16), 32'(k + 256));
        pulse_a();
        chk("rs_busy",  a_busy[4], 1);
        chk("rs_done0", a_done[4], 0);
        chk("rs_load",  a_out[4],  mk(1, 4'(12), 32'(260)));
        step(15);
        chk("rs_early", a_done[9], 0);
        step(1);
        chk("rs_done", a_done[9], 1);
        for (int j = 0; j < 16; j++)
            chk($sformatf("rs_r%0d", j), a_res[j], mk(1, 4'(j), 32'(((7 * j) % 16) + 256)));

        // Asynchronous reset in the middle of a sort
        for (int k = 0; k < 16; k++) a_ld[k] = mk(1, 4'(15 - k), 32'(k));
        pulse_a();
        step(5);
        chk("ar_busy_pre", a_busy[3], 1);
        #3 rst = 1'b1;
        #1;
        chk("ar_out",  a_out[3],  '0);
        chk("ar_busy", a_busy[3], 0);
        chk("ar_res",  a_res[3],  '0);
        #2 rst = 1'b0;
        step(20);
        chk("ar_no_done", a_done[0],  0);
        chk("ar_no_busy", a_busy[15], 0);
        chk("ar_out_idle", a_out[0],  '0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
